// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants and types for the multiplier datapath
package mult_pkg;

  localparam int PW        = 64;
  localparam int GW        = 8;
  localparam int MAX_TERMS = 256;

  typedef enum logic {ACC, HOLD} state_t;

  typedef logic [PW-1:0]    prod_t;
  typedef logic [PW+GW-1:0] acc_t;

endpackage

// File: rtl/mult_prod_acc.sv
// rtl/mult_prod_acc.sv - group accumulator for 64-bit products with registered result handshake
module mult_prod_acc #(
  parameter int PW        = mult_pkg::PW,
  parameter int GW        = mult_pkg::GW,
  parameter int MAX_TERMS = mult_pkg::MAX_TERMS,
  parameter int CW        = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PW-1:0]    in_p,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PW+GW-1:0] out_sum,
  output logic [CW-1:0]    out_cnt,
  output logic             out_forced
);

  mult_pkg::state_t state, state_nxt;

  logic [PW+GW-1:0] acc;
  logic [PW+GW-1:0] sum_nxt;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             closing;

  // acc is always zero in HOLD, so a beat taken there starts a fresh group
  assign in_ready  = (state == mult_pkg::ACC) ? 1'b1 : out_ready;
  assign out_valid = (state == mult_pkg::HOLD);
  assign accept    = in_valid && in_ready;
  assign closing   = accept && (in_last || (cnt == CW'(MAX_TERMS - 1)));
  assign sum_nxt   = acc + {{GW{1'b0}}, in_p};

  always_comb begin
    state_nxt = state;
    case (state)
      mult_pkg::ACC:  if (closing) state_nxt = mult_pkg::HOLD;
      mult_pkg::HOLD: if (out_ready && !closing) state_nxt = mult_pkg::ACC;
      default:        state_nxt = mult_pkg::ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= mult_pkg::ACC;
      acc        <= '0;
      cnt        <= '0;
      out_sum    <= '0;
      out_cnt    <= '0;
      out_forced <= 1'b0;
    end else begin
      state <= state_nxt;
      if (closing) begin
        out_sum    <= sum_nxt;
        out_cnt    <= cnt + 1'b1;
        out_forced <= ~in_last;
        acc        <= '0;
        cnt        <= '0;
      end else if (accept) begin
        acc <= sum_nxt;
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mult_prod_acc.sv
// tb/tb_mult_prod_acc.sv - self-checking bench for mult_prod_acc
module tb_mult_prod_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_p = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [71:0] out_sum;
  logic [8:0]  out_cnt;
  logic        out_forced;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [71:0] sum;
    logic [8:0]  cnt;
    logic        forced;
  } exp_t;

  exp_t        q[$];
  logic [71:0] m_acc = '0;
  int          m_cnt = 0;
  int          pushed = 0;
  int          popped = 0;

  always #5 clk = ~clk;

  mult_prod_acc dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_p       (in_p),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_cnt    (out_cnt),
    .out_forced (out_forced)
  );

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // scoreboard: model acceptance from its own view of HOLD and compare every handshake
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_acc = '0;
      m_cnt = 0;
    end else begin
      logic exp_ready;
      exp_t e;
      exp_ready = (q.size() == 0) || out_ready;
      chk("mon_in_ready", {71'd0, in_ready}, {71'd0, exp_ready});
      chk("mon_out_valid", {71'd0, out_valid}, {71'd0, q.size() != 0});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mon_extra_result actual=%h expected=none", out_sum);
        end else begin
          e = q.pop_front();
          popped++;
          chk("mon_sum", out_sum, e.sum);
          chk("mon_cnt", {63'd0, out_cnt}, {63'd0, e.cnt});
          chk("mon_forced", {71'd0, out_forced}, {71'd0, e.forced});
        end
      end
      if (in_valid && exp_ready) begin
        if (in_last || m_cnt == 255) begin
          e.sum    = m_acc + {8'd0, in_p};
          e.cnt    = 9'(m_cnt + 1);
          e.forced = !in_last;
          q.push_back(e);
          pushed++;
          m_acc = '0;
          m_cnt = 0;
        end else begin
          m_acc = m_acc + {8'd0, in_p};
          m_cnt++;
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [63:0] p, input logic last);
    in_valid = v;
    in_p     = p;
    in_last  = last;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        v;
    logic [63:0] p;
    logic        last;
    logic        exp_valid;
    logic [71:0] exp_sum;
    logic [8:0]  exp_cnt;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 64'hFFFFFFFE00000001, 1'b1, 1'b1, 72'h00FFFFFFFE00000001, 9'd1};
    tbl[1] = '{1'b1, 64'd5,  1'b0, 1'b0, 72'd0, 9'd0};
    tbl[2] = '{1'b1, 64'd7,  1'b0, 1'b0, 72'd0, 9'd0};
    tbl[3] = '{1'b1, 64'd11, 1'b1, 1'b1, 72'd23, 9'd3};
    tbl[4] = '{1'b0, 64'd0,  1'b0, 1'b0, 72'd0, 9'd0};
    tbl[5] = '{1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b1, 72'h00FFFFFFFFFFFFFFFF, 9'd1};
    tbl[6] = '{1'b1, 64'd1,  1'b1, 1'b1, 72'd1, 9'd1};
    tbl[7] = '{1'b0, 64'd0,  1'b0, 1'b0, 72'd0, 9'd0};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_out_valid", {71'd0, out_valid}, 72'd0);
    chk("reset_out_sum", out_sum, 72'd0);
    chk("reset_out_cnt", {63'd0, out_cnt}, 72'd0);
    chk("reset_out_forced", {71'd0, out_forced}, 72'd0);
    chk("reset_in_ready", {71'd0, in_ready}, 72'd1);

    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].p, tbl[i].last);
      chk($sformatf("tbl%0d_valid", i), {71'd0, out_valid}, {71'd0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) begin
        chk($sformatf("tbl%0d_sum", i), out_sum, tbl[i].exp_sum);
        chk($sformatf("tbl%0d_cnt", i), {63'd0, out_cnt}, {63'd0, tbl[i].exp_cnt});
        chk($sformatf("tbl%0d_forced", i), {71'd0, out_forced}, 72'd0);
      end
    end

    for (int i = 0; i < 256; i++) drive(1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    chk("forced_valid", {71'd0, out_valid}, 72'd1);
    chk("forced_sum", out_sum, 72'hFFFFFFFFFFFFFFFF00);
    chk("forced_cnt", {63'd0, out_cnt}, 72'd256);
    chk("forced_flag", {71'd0, out_forced}, 72'd1);
    drive(1'b1, 64'd4, 1'b1);
    chk("after_forced_sum", out_sum, 72'd4);
    chk("after_forced_cnt", {63'd0, out_cnt}, 72'd1);
    chk("after_forced_flag", {71'd0, out_forced}, 72'd0);
    drive(1'b0, 64'd0, 1'b0);

    for (int i = 0; i < 255; i++) drive(1'b1, 64'd1, 1'b0);
    drive(1'b1, 64'd1, 1'b1);
    chk("last_at_max_sum", out_sum, 72'd256);
    chk("last_at_max_cnt", {63'd0, out_cnt}, 72'd256);
    chk("last_at_max_forced", {71'd0, out_forced}, 72'd0);
    drive(1'b0, 64'd0, 1'b0);

    out_ready = 1'b0;
    drive(1'b1, 64'd3, 1'b1);
    chk("bp_valid", {71'd0, out_valid}, 72'd1);
    in_valid = 1'b1;
    in_p     = 64'd9;
    in_last  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("bp_in_ready", {71'd0, in_ready}, 72'd0);
      chk("bp_sum_stable", out_sum, 72'd3);
      chk("bp_cnt_stable", {63'd0, out_cnt}, 72'd1);
      chk("bp_valid_stable", {71'd0, out_valid}, 72'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_next_sum", out_sum, 72'd9);
    chk("bp_next_cnt", {63'd0, out_cnt}, 72'd1);
    chk("bp_next_valid", {71'd0, out_valid}, 72'd1);
    drive(1'b0, 64'd0, 1'b0);

    drive(1'b1, 64'd100, 1'b0);
    drive(1'b1, 64'd200, 1'b0);
    rst = 1'b1;
    drive(1'b1, 64'd50, 1'b1);
    rst = 1'b0;
    chk("rst_mid_valid", {71'd0, out_valid}, 72'd0);
    chk("rst_mid_sum", out_sum, 72'd0);
    chk("rst_mid_in_ready", {71'd0, in_ready}, 72'd1);
    drive(1'b1, 64'd1, 1'b1);
    chk("rst_mid_after_sum", out_sum, 72'd1);
    chk("rst_mid_after_cnt", {63'd0, out_cnt}, 72'd1);
    drive(1'b0, 64'd0, 1'b0);

    for (int i = 0; i < 4000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_p      = {$urandom, $urandom};
      in_last   = (i < 2000) ? (($urandom % 6) == 0) : (($urandom % 400) == 0);
      out_ready = ($urandom % 3) != 0;
      @(posedge clk);
      #1;
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 72'(q.size()), 72'd0);
    chk("results_balance", 72'(popped), 72'(pushed));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
